// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The FETCH_PERF_EN build adds wait/flush performance counters.
package instr_fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_REQ  = 2'b01,
    FETCH_HOLD = 2'b10,
    FETCH_DROP = 2'b11
  } fetch_state_e;

  // Instruction word together with the PC it was fetched from
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] word;
  } fetch_inst_t;

endpackage

// File: rtl/instr_fetch_sat_counter.sv
// Saturating event counter, used only by the FETCH_PERF_EN build.
`ifdef FETCH_PERF_EN
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/instr_fetch.sv
// Fetch stage: issues word reads over req/ack, holds the instruction for decode,
// and drops wrong-path fetches on flush. FETCH_PERF_EN adds perf counters.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_W   = 10,
  parameter logic [FETCH_XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic [FETCH_XLEN-1:0] i_pc_in,
  input  logic                  i_flush,
  output logic                  o_imem_req,
  output logic [ADDR_W-1:0]     o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [FETCH_XLEN-1:0] i_imem_rdata,
  output logic                  o_inst_valid,
  output logic [FETCH_XLEN-1:0] o_inst,
  output logic [FETCH_XLEN-1:0] o_inst_pc,
  input  logic                  i_dec_ready,
`ifdef FETCH_PERF_EN
  output logic [FETCH_XLEN-1:0] o_mem_wait_cycles,
  output logic [FETCH_XLEN-1:0] o_flush_count,
`endif
  output logic                  o_fetch_stall
);

  fetch_state_e          r_state,       w_state_nxt;
  logic [FETCH_XLEN-1:0] r_req_pc,      w_req_pc_nxt;
  logic [FETCH_XLEN-1:0] r_redirect_pc, w_redirect_pc_nxt;
  fetch_inst_t           r_inst,        w_inst_nxt;
  logic                  r_inst_valid,  w_inst_valid_nxt;
  logic                  r_imem_req,    w_imem_req_nxt;

  // State and datapath registers; clr also abandons any in-flight request
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state       <= FETCH_IDLE;
      r_req_pc      <= RESET_PC;
      r_redirect_pc <= '0;
      r_inst        <= '0;
      r_inst_valid  <= 1'b0;
      r_imem_req    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_req_pc      <= w_req_pc_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_inst        <= w_inst_nxt;
      r_inst_valid  <= w_inst_valid_nxt;
      r_imem_req    <= w_imem_req_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt       = r_state;
    w_req_pc_nxt      = r_req_pc;
    w_redirect_pc_nxt = r_redirect_pc;
    w_inst_nxt        = r_inst;
    w_inst_valid_nxt  = r_inst_valid;

    unique case (r_state)
      FETCH_IDLE: begin
        w_state_nxt = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (i_imem_ack && !i_flush) begin
          w_inst_nxt.word  = i_imem_rdata;
          w_inst_nxt.pc    = r_req_pc;
          w_inst_valid_nxt = 1'b1;
          w_state_nxt      = FETCH_HOLD;
        end else if (i_imem_ack && i_flush) begin
          w_req_pc_nxt = i_pc_in;
        end else if (i_flush) begin
          w_redirect_pc_nxt = i_pc_in;
          w_state_nxt       = FETCH_DROP;
        end
      end
      FETCH_HOLD: begin
        // flush and consume both retire the held word; flush takes priority for stall
        if (i_flush || i_dec_ready) begin
          w_inst_valid_nxt = 1'b0;
          w_req_pc_nxt     = i_pc_in;
          w_state_nxt      = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        // Address stays put until the abandoned read completes
        if (i_flush) begin
          w_redirect_pc_nxt = i_pc_in;
        end
        if (i_imem_ack) begin
          w_req_pc_nxt = i_flush ? i_pc_in : r_redirect_pc;
          w_state_nxt  = FETCH_REQ;
        end
      end
      default: begin
        w_state_nxt = FETCH_IDLE;
      end
    endcase

    w_imem_req_nxt = (w_state_nxt == FETCH_REQ) || (w_state_nxt == FETCH_DROP);
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_req_pc[ADDR_W-1:0];
  assign o_inst_valid  = r_inst_valid;
  assign o_inst        = r_inst.word;
  assign o_inst_pc     = r_inst.pc;
  assign o_fetch_stall = !((r_state == FETCH_HOLD) && i_dec_ready && !i_flush);

`ifdef FETCH_PERF_EN
  sat_counter #(.WIDTH(FETCH_XLEN)) u_wait_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_clr),
    .i_inc   (r_imem_req && !i_imem_ack),
    .o_count (o_mem_wait_cycles)
  );

  sat_counter #(.WIDTH(FETCH_XLEN)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_clr),
    .i_inc   (i_flush),
    .o_count (o_flush_count)
  );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic
// checked against a transaction-level fetch model. Honors FETCH_PERF_EN.
module tb_instr_fetch;

  localparam int unsigned ADDR_W   = 10;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              clr;
  logic [31:0]       i_pc_in;
  logic              i_flush;
  logic              o_imem_req;
  logic [ADDR_W-1:0] o_imem_addr;
  logic              i_imem_ack;
  logic [31:0]       i_imem_rdata;
  logic              o_inst_valid;
  logic [31:0]       o_inst;
  logic [31:0]       o_inst_pc;
  logic              i_dec_ready;
  logic              o_fetch_stall;
`ifdef FETCH_PERF_EN
  logic [31:0]       o_mem_wait_cycles;
  logic [31:0]       o_flush_count;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: fetch-stage status as plain flags and values
  bit          m_idle, m_pending, m_discard, m_have;
  logic [31:0] m_addr, m_redir, m_inst, m_inst_pc, m_wait, m_flush;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .i_clk             (clk),
    .i_clr             (clr),
    .i_pc_in           (i_pc_in),
    .i_flush           (i_flush),
    .o_imem_req        (o_imem_req),
    .o_imem_addr       (o_imem_addr),
    .i_imem_ack        (i_imem_ack),
    .i_imem_rdata      (i_imem_rdata),
    .o_inst_valid      (o_inst_valid),
    .o_inst            (o_inst),
    .o_inst_pc         (o_inst_pc),
    .i_dec_ready       (i_dec_ready),
`ifdef FETCH_PERF_EN
    .o_mem_wait_cycles (o_mem_wait_cycles),
    .o_flush_count     (o_flush_count),
`endif
    .o_fetch_stall     (o_fetch_stall)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [ADDR_W-1:0] w;
    w = a[ADDR_W-1:0];
    return {16'hC0DE ^ 16'(w), 16'(w) ^ 16'h5A5A};
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_pending = 1'b0; m_discard = 1'b0; m_have = 1'b0;
    m_addr = RESET_PC; m_redir = '0; m_inst = '0; m_inst_pc = '0;
    m_wait = '0; m_flush = '0;
  endtask

  // One clock: drive, check against model, advance model across the edge
  task automatic step(input bit fl, input logic [31:0] pc, input bit ack, input bit dec);
    @(negedge clk);
    i_flush = fl; i_pc_in = pc; i_imem_ack = ack; i_dec_ready = dec;
    i_imem_rdata = ack ? mem_word(m_addr) : $urandom();
    #1;
    check1("imem_req", o_imem_req, m_pending);
    if (m_pending) check32("imem_addr", 32'(o_imem_addr), 32'(m_addr[ADDR_W-1:0]));
    check1("inst_valid", o_inst_valid, m_have);
    check32("inst", o_inst, m_inst);
    check32("inst_pc", o_inst_pc, m_inst_pc);
    check1("fetch_stall", o_fetch_stall, !(m_have && dec && !fl));
`ifdef FETCH_PERF_EN
    check32("mem_wait_cycles", o_mem_wait_cycles, m_wait);
    check32("flush_count", o_flush_count, m_flush);
`endif
    if (m_pending && !ack && m_wait != 32'hFFFF_FFFF) m_wait = m_wait + 32'd1;
    if (fl && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
    if (m_idle) begin
      m_idle = 1'b0; m_pending = 1'b1; m_addr = RESET_PC;
    end else if (m_pending && !m_discard) begin
      if (ack && !fl) begin
        m_have = 1'b1; m_pending = 1'b0; m_inst_pc = m_addr; m_inst = mem_word(m_addr);
      end else if (ack) begin
        m_addr = pc;
      end else if (fl) begin
        m_discard = 1'b1; m_redir = pc;
      end
    end else if (m_pending) begin
      if (fl) m_redir = pc;
      if (ack) begin
        m_addr = fl ? pc : m_redir; m_discard = 1'b0;
      end
    end else if (m_have && (fl || dec)) begin
      m_have = 1'b0; m_pending = 1'b1; m_addr = pc;
    end
    @(posedge clk);
  endtask

  // Assert clr between edges and confirm the outputs fall without a clock
  task automatic async_clr();
    @(negedge clk);
    i_flush = 1'b0; i_imem_ack = 1'b0;
    #1;
    check1("pre_clr_req", o_imem_req, m_pending);
    check1("pre_clr_valid", o_inst_valid, m_have);
    clr = 1'b1;
    #1;
    check1("clr_req", o_imem_req, 1'b0);
    check1("clr_valid", o_inst_valid, 1'b0);
    check1("clr_stall", o_fetch_stall, 1'b1);
    check32("clr_inst_pc", o_inst_pc, 32'h0);
`ifdef FETCH_PERF_EN
    check32("clr_wait_cnt", o_mem_wait_cycles, 32'h0);
    check32("clr_flush_cnt", o_flush_count, 32'h0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    bit fl, ack, dec;
    clr = 1'b1; i_pc_in = '0; i_flush = 1'b0; i_imem_ack = 1'b0;
    i_imem_rdata = '0; i_dec_ready = 1'b0;
    model_reset();
    #2;
    check1("rst_req", o_imem_req, 1'b0);
    check1("rst_valid", o_inst_valid, 1'b0);
    check32("rst_inst", o_inst, 32'h0);
    check32("rst_inst_pc", o_inst_pc, 32'h0);
    check1("rst_stall", o_fetch_stall, 1'b1);
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Zero-wait memory, decode always ready, sequential PCs
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, m_inst_pc + 32'd1, m_pending, 1'b1);

    // Three wait cycles at address 5, then a four-cycle decode stall
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, $urandom(), 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, $urandom(), 1'b0, 1'b0);

    // Flush during an unacked request at 7 redirects to 0x40
    step(1'b0, 32'h7, 1'b0, 1'b1);
    step(1'b1, 32'h40, 1'b0, 1'b1);
    step(1'b0, $urandom(), 1'b0, 1'b1);
    step(1'b0, $urandom(), 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush beats dec_ready while holding
    step(1'b1, 32'h20, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush coinciding with ack restarts at the new PC
    step(1'b0, 32'h9, 1'b0, 1'b1);
    step(1'b1, 32'hC, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Repeated flushes while dropping: latest target wins; address wraps
    step(1'b1, 32'h100, 1'b0, 1'b1);
    step(1'b1, 32'h200, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0405, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // clr mid-request, then clr while holding
    async_clr();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    async_clr();
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      fl  = (!m_idle) && ($urandom_range(0, 7) == 0);
      ack = m_pending && ($urandom_range(0, 1) == 1);
      dec = ($urandom_range(0, 9) < 7);
      step(fl, $urandom(), ack, dec);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage; consumes the word-granular PC from the PC-update unit and reads instruction memory over a req/ack handshake.
- Holds the fetched instruction for decode.
- Returns the fetched instruction's PC to the PC unit, which uses it as the base for its next update.
- Stalls the PC unit while memory is busy or decode is not ready, and discards wrong-path fetches on flush.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; imem_addr = req_pc[ADDR_W-1:0].
- RESET_PC, 32'h0, PC fetched after reset; word address.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  reset; asynchronous, active-high.
- pc_in  in  32  next word address from the PC unit.
- flush  in  1  one-cycle redirect; pc_in already holds the target in that cycle.
- imem_req  out  1  memory read request.
- imem_addr  out  ADDR_W  word address; stable while imem_req is high.
- imem_ack  in  1  read data valid this cycle; may assert in the first req cycle.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst/inst_pc valid for decode.
- inst  out  32  held instruction.
- inst_pc  out  32  PC of inst; feeds the PC unit's last_pc.
- dec_ready  in  1  decode accepts inst this cycle.
- fetch_stall  out  1  PC unit must hold current_pc.

Behaviour:
- Reset (clr high, any state):
  - state=IDLE, req_pc=RESET_PC, redirect_pc=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - imem_req=0, fetch_stall=1.
- 2-bit FSM, states IDLE, REQ, HOLD, DROP:
  - IDLE: first edge after clr deasserts → REQ using req_pc=RESET_PC. pc_in is ignored in IDLE.
  - REQ: imem_req=1, imem_addr=req_pc[ADDR_W-1:0].
    - ack && !flush → inst<=imem_rdata, inst_pc<=req_pc, inst_valid<=1, go HOLD.
    - ack && flush → discard data, req_pc<=pc_in, stay REQ.
    - !ack && flush → redirect_pc<=pc_in, go DROP.
    - !ack && !flush → stay REQ.
  - HOLD: inst_valid=1, imem_req=0.
    - flush → inst_valid<=0, req_pc<=pc_in, go REQ.
    - dec_ready && !flush → inst_valid<=0, req_pc<=pc_in, go REQ.
    - otherwise hold all outputs unchanged.
  - DROP: imem_req=1 at the old address; the address must not change mid-handshake.
    - flush → redirect_pc<=pc_in (latest redirect wins).
    - ack → discard data, req_pc<=(flush ? pc_in : redirect_pc), go REQ.
- fetch_stall = !(state==HOLD && dec_ready && !flush). Deasserts exactly in the cycle the instruction is consumed.
- inst_valid is never 1 in REQ/DROP/IDLE. A flushed instruction is never presented.
- Latency and throughput:
  - zero-wait memory (ack in first req cycle): 1 cycle from REQ entry to inst_valid.
  - peak throughput: 1 instruction per 2 cycles.
- Address width: bits of req_pc above ADDR_W are ignored. Addresses alias and wrap modulo 2^ADDR_W; no error is flagged.
- Simultaneous flush && dec_ready in HOLD: flush wins; the instruction is counted as not consumed.
- clr mid-handshake: the request is abandoned immediately (imem_req=0 asynchronously). Memory must tolerate a dropped request.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - extra output mem_wait_cycles (32): increments each cycle imem_req && !imem_ack.
  - extra output flush_count (32): increments on each flush.
  - both saturate at 32'hFFFFFFFF and clear on clr.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- defines.vh gets:
  - state encodings FETCH_IDLE=2'b00, FETCH_REQ=2'b01, FETCH_HOLD=2'b10, FETCH_DROP=2'b11;
  - FETCH_RESET_PC.
- Core is a single module; no sub-module.
- Under FETCH_PERF_EN, one small sub-module sat_counter (width parameter, inc/clr, saturating) is instantiated twice.

Test Plan:
- Reset then zero-wait memory, dec_ready=1, pc_in tracks inst_pc+1:
  - imem_addr 0,1,2,3 on every other cycle;
  - inst_valid pulses with inst_pc 0,1,2,3;
  - fetch_stall low only in the consume cycles.
- ack delayed 3 cycles at addr 5: imem_req and imem_addr=5 stable for 4 cycles; fetch_stall=1 throughout; then inst_valid with inst_pc=5.
- HOLD with dec_ready=0 for 4 cycles: inst/inst_pc unchanged; imem_req=0; fetch_stall=1.
- flush with pc_in=32'h40 during REQ without ack (old addr 7):
  - enters DROP, addr 7 held;
  - ack data discarded; next request addr 32'h40;
  - no inst_valid for addr 7.
- flush in HOLD with dec_ready=1, pc_in=32'h20: held instruction dropped; next request addr 32'h20; flush wins over dec_ready.
- clr asserted mid-REQ:
  - imem_req and inst_valid drop without waiting for clk;
  - after release, fetch restarts at RESET_PC;
  - under FETCH_PERF_EN, counters read 0.
